// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  // RISC-V M-extension funct3 encodings.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  // Divider iteration counter is sized for the widest supported XLEN, so
  // one width serves both RV32 and RV64 builds.
  localparam int MAX_XLEN = 64;
  localparam int CNT_W    = $clog2(MAX_XLEN);

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; 'done' pulses for one cycle after the
// last iteration, with quotient/remainder held until the next start.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
  end

  // Iteration state: load on start, shift/subtract while running.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        running <= 1'b0;
      end else if (start) begin
        rem     <= '0;
        quo     <= dividend;
        dvs     <= divisor;
        cnt     <= CNT_W'(XLEN - 1);
        running <= 1'b1;
      end else if (running) begin
        if (!diff[XLEN]) begin
          rem <= diff[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem <= shifted[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end
        if (cnt == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply-divide unit with valid/ready handshake and flush.
// Multiplies complete MUL_LAT cycles after acceptance; divides go through
// the iterative core and a sign-fix cycle, or a one-cycle fast path for
// divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_n;
  op_t               op_q;
  logic [XLEN-1:0]   src1_q, src2_q;
  logic [TAG_W-1:0]  tag_q;
  logic [1:0]        mul_cnt;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_out_q;

  logic              accept, in_signed, fast, div_start, div_done;
  logic [XLEN-1:0]   fast_res, mag1, mag2, raw_quo, raw_rem;
  logic [2*XLEN-1:0] a_ext, b_ext, product;
  logic [XLEN-1:0]   mul_res, fix_res;
  logic              load_res;
  logic [XLEN-1:0]   res_n;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;
  assign tag_out   = tag_out_q;
  assign accept    = in_valid && in_ready && !flush;

  // Fast-path detection, fast results and operand magnitudes from the inputs.
  always_comb begin
    in_signed = !op[0];
    fast      = op[2] && ((src2 == '0) ||
                (in_signed && (src1 == MOST_NEG) && (src2 == '1)));
    if (src2 == '0) fast_res = op[1] ? src1 : '1;
    else            fast_res = op[1] ? '0 : src1;
    mag1      = (in_signed && src1[XLEN-1]) ? -src1 : src1;
    mag2      = (in_signed && src2[XLEN-1]) ? -src2 : src2;
    div_start = accept && op[2] && !fast;
  end

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag1),
    .divisor   (mag2),
    .done      (div_done),
    .quotient  (raw_quo),
    .remainder (raw_rem)
  );

  // Multiply result and divide sign correction from the captured operands.
  always_comb begin
    a_ext = (op_q == OP_MULH || op_q == OP_MULHSU) ?
            {{XLEN{src1_q[XLEN-1]}}, src1_q} : {{XLEN{1'b0}}, src1_q};
    b_ext = (op_q == OP_MULH) ?
            {{XLEN{src2_q[XLEN-1]}}, src2_q} : {{XLEN{1'b0}}, src2_q};
    product = a_ext * b_ext;
    mul_res = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    if (op_q[1])
      fix_res = (!op_q[0] && src1_q[XLEN-1]) ? -raw_rem : raw_rem;
    else
      fix_res = (!op_q[0] && (src1_q[XLEN-1] ^ src2_q[XLEN-1])) ? -raw_quo : raw_quo;
  end

  // Next-state logic and result selection on entry to DONE.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    load_res = 1'b0;
    res_n    = result_q;
    case (state)
      ST_IDLE: if (accept) begin
        if (!op[2]) state_n = ST_MUL;
        else if (fast) begin
          state_n  = ST_DONE;
          load_res = 1'b1;
          res_n    = fast_res;
        end else state_n = ST_DIV;
      end
      ST_MUL: if (mul_cnt == 2'd0) begin
        state_n  = ST_DONE;
        load_res = 1'b1;
        res_n    = mul_res;
      end
      ST_DIV: if (div_done) state_n = ST_FIX;
      ST_FIX: begin
        state_n  = ST_DONE;
        load_res = 1'b1;
        res_n    = fix_res;
      end
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n  = ST_IDLE;
      load_res = 1'b0;
    end
  end

  // State, captured operands, multiply countdown and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MUL;
      src1_q    <= '0;
      src2_q    <= '0;
      tag_q     <= '0;
      mul_cnt   <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q    <= op_t'(op);
        src1_q  <= src1;
        src2_q  <= src2;
        tag_q   <= tag_in;
        mul_cnt <= 2'(MUL_LAT - 1);
      end else if (state == ST_MUL && mul_cnt != 2'd0) begin
        mul_cnt <= mul_cnt - 2'd1;
      end
      if (load_res) begin
        result_q  <= res_n;
        tag_out_q <= (state == ST_IDLE) ? tag_in : tag_q;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised RV32M/RV64M multiply-divide unit; successor to the single-cycle combinational multiplier path of the EX-stage ALU.
- Executes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - Multiply: fixed-latency register pipeline.
  - Divide: iterative radix-2 restoring divider.
- Sits beside the ALU in EX. Uses a valid/ready handshake plus a flush input, so the pipeline controller can stall or kill it.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- MUL_LAT, 2, multiply latency in cycles from acceptance to out_valid (1..3).
- TAG_W, 5, width of the destination-register tag carried through with the operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept an operation.
- op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  input  XLEN  rs1 operand.
- src2  input  XLEN  rs2 operand.
- tag_in  input  TAG_W  destination tag.
- flush  input  1  synchronous abort of any in-flight operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- tag_out  output  TAG_W  tag of the operation on result.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE.
  - out_valid=0, result=0, tag_out=0, busy=0, in_ready=1.
  - Internal counters and operand registers are cleared.
- Acceptance:
  - An operation is accepted on a rising edge where in_valid && in_ready && !flush.
  - op, src1, src2 and tag_in are captured at that edge.
  - Only one operation is in flight at a time.
  - in_ready = (state==IDLE).
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on accepted op[2]=0.
  - IDLE -> DIV on accepted op[2]=1 with a normal divisor.
  - IDLE -> DONE on accepted divide taking the fast path (see special cases).
  - MUL -> DONE after MUL_LAT-1 further cycles. out_valid rises exactly MUL_LAT edges after the acceptance edge.
  - DIV iterates XLEN cycles (counter XLEN-1 down to 0), then -> FIX.
  - FIX applies sign correction to quotient/remainder, then -> DONE. out_valid rises XLEN+2 edges after the acceptance edge.
  - DONE holds result, tag_out and out_valid=1 until out_ready=1, then -> IDLE.
  - A new op is accepted no earlier than the edge after the result is accepted.
- Multiply arithmetic:
  - Form a 2*XLEN product of operands extended according to op.
  - MULH: both operands sign-extended.
  - MULHSU: src1 sign-extended, src2 zero-extended.
  - MULHU: both operands zero-extended.
  - MUL returns product[XLEN-1:0]; the three high variants return product[2*XLEN-1:XLEN].
- Divide arithmetic:
  - Signed ops (DIV, REM) divide magnitudes and restore signs in FIX.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide special cases (fast path: one cycle, out_valid 1 edge after acceptance, FIX skipped):
  - Divisor==0:
    - DIV/DIVU result all ones.
    - REM/REMU result = src1.
  - Signed overflow (src1 = most negative value, src2 = -1, DIV/REM only):
    - DIV result = src1.
    - REM result = 0.
- Flush:
  - Highest priority below reset.
  - In any state, flush=1 at an edge sends the FSM to IDLE, with out_valid=0 after that edge.
  - The in-flight result is discarded, including a result in DONE not yet accepted.
  - An in_valid coincident with flush is not accepted.
- Stability:
  - result and tag_out change only on the transition into DONE or on reset.
  - While out_valid=1 and out_ready=0, both are stable.
- Reset mid-operation aborts immediately, same as the reset values above.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum of FSM states.
  - typedef enum of op codes (funct3 values above).
  - localparam for the counter width $clog2(XLEN).
- One sub-module: muldiv_divider. It holds the iterative restoring core with start/done, dividend/divisor magnitudes in, and raw quotient/remainder out.
- Sign handling, the fast path and the multiply pipeline stay in the top level.

Test Plan:
- MULHSU, src1=32'hFFFF_FFFF (-1), src2=32'h0000_0002, MUL_LAT=2 -> result 32'hFFFF_FFFF, out_valid 2 edges after accept, tag_out equals tag_in.
- MULHU, src1=src2=32'hFFFF_FFFF -> result 32'hFFFF_FFFE; MUL with the same operands -> 32'h0000_0001.
- DIV, src1=-7, src2=2 -> result 32'hFFFF_FFFD (-3), out_valid exactly 34 edges after accept; REM with the same operands -> 32'hFFFF_FFFF (-1).
- DIVU, src2=0, src1=32'h1234 -> result 32'hFFFF_FFFF after 1 edge; REM, src1=32'h8000_0000, src2=32'hFFFF_FFFF -> result 0 after 1 edge.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, result and tag_out stable and in_ready=0 throughout; result accepted on the first out_ready=1.
- Flush at iteration 10 of a DIVU -> out_valid never rises, in_ready=1 on the next edge. Then a new MUL (3*5) -> result 15. Repeat with rst_n pulsed low mid-divide -> all outputs at reset values asynchronously.
